// File: rtl/ro_scan_scheduler.sv
// ro_scan_scheduler: steps through the enabled ring oscillators one at a time, gating a
// shared edge counter for a fixed window and handing each count to a shared UART sender.
// Optional build macro RO_SCAN_TAG_EN: when defined, each sent word carries the channel
// index in bits [31:28] and the count is saturated to 28 bits; otherwise the raw count is sent.
module ro_scan_scheduler #(
    parameter int unsigned N_RO          = 4,
    parameter int unsigned GATE_CYCLES   = 1000000,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SEND_TIMEOUT  = 2000000,
    localparam int unsigned IDX_W        = (N_RO > 1) ? $clog2(N_RO) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic [N_RO-1:0]  ro_mask,
    output logic [IDX_W-1:0] ro_sel,
    output logic             ro_en,
    output logic             cnt_clear,
    output logic             cnt_gate,
    input  logic [31:0]      cnt_value,
    output logic [31:0]      send_data,
    output logic             send_req,
    input  logic             send_done,
    output logic             busy,
    output logic             meas_valid,
    output logic [IDX_W-1:0] meas_id,
    output logic             timeout_err
);

    // Terminal values of the shared phase counter; each phase restarts it at zero.
    localparam logic [31:0] SettleLast  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] GateLast    = 32'(GATE_CYCLES - 1);
    localparam logic [31:0] TimeoutLast = 32'(SEND_TIMEOUT - 1);
    // Second drain cycle: the counter result has crossed its synchroniser by then.
    localparam logic [31:0] DrainLast   = 32'd1;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StGate,
        StDrain,
        StSend,
        StWaitDone,
        StNext
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0] ro_sel_q, ro_sel_d;
    logic [N_RO-1:0]  mask_q, mask_d;
    logic [31:0]      data_q, data_d;
    logic             meas_valid_q, meas_valid_d;
    logic [IDX_W-1:0] meas_id_q, meas_id_d;
    logic             timeout_err_q, timeout_err_d;

    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] wrap_idx;
    logic [IDX_W-1:0] next_idx;
    logic             next_found;
    logic [31:0]      latch_word;

    // Lowest set bit of a mask; callers guarantee the mask is non-zero.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_RO-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_RO - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // First channel of a new scan (from the live mask) and wrap target (from the latched mask).
    always_comb begin
        start_idx = lowest_set(ro_mask);
        wrap_idx  = lowest_set(mask_q);
    end

    // Next enabled channel strictly above the current one in the latched mask.
    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        for (int i = N_RO - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ro_sel_q))) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(i);
            end
        end
    end

`ifdef RO_SCAN_TAG_EN
    logic [3:0]  tag;
    logic [27:0] cnt_sat;

    // Tagged word: channel in the top nibble, count clipped to the remaining 28 bits.
    always_comb begin
        tag        = 4'(ro_sel_q);
        cnt_sat    = (cnt_value[31:28] != 4'd0) ? 28'hFFF_FFFF : cnt_value[27:0];
        latch_word = {tag, cnt_sat};
    end
`else
    // Untagged word: the raw counter result.
    always_comb begin
        latch_word = cnt_value;
    end
`endif

    // Next-state and output decode for the scan sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ro_sel_d      = ro_sel_q;
        mask_d        = mask_q;
        data_d        = data_q;
        meas_valid_d  = 1'b0;
        meas_id_d     = meas_id_q;
        timeout_err_d = timeout_err_q;
        ro_en         = 1'b0;
        cnt_clear     = 1'b0;
        cnt_gate      = 1'b0;
        send_req      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start && (ro_mask != '0)) begin
                    mask_d        = ro_mask;
                    timeout_err_d = 1'b0;
                    ro_sel_d      = start_idx;
                    state_d       = StSettle;
                end
            end

            StSettle: begin
                ro_en     = 1'b1;
                cnt_clear = (cnt_q == '0);
                if (cnt_q == SettleLast) begin
                    cnt_d   = '0;
                    state_d = StGate;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StGate: begin
                ro_en    = 1'b1;
                cnt_gate = 1'b1;
                if (cnt_q == GateLast) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StDrain: begin
                // Keep the RO running so the last edges inside the window still get counted.
                ro_en = 1'b1;
                if (cnt_q == DrainLast) begin
                    cnt_d        = '0;
                    data_d       = latch_word;
                    meas_valid_d = 1'b1;
                    meas_id_d    = ro_sel_q;
                    state_d      = StSend;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StSend: begin
                send_req = 1'b1;
                cnt_d    = '0;
                state_d  = StWaitDone;
            end

            StWaitDone: begin
                if (send_done) begin
                    cnt_d   = '0;
                    state_d = StNext;
                end else if (cnt_q == TimeoutLast) begin
                    // A stuck sender must not stall the scan; flag it and move on.
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                    state_d       = StNext;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StNext: begin
                cnt_d = '0;
                if (next_found) begin
                    ro_sel_d = next_idx;
                    state_d  = StSettle;
                end else if (continuous) begin
                    // Wrap using the mask captured at scan start, not the live input.
                    ro_sel_d = wrap_idx;
                    state_d  = StSettle;
                end else begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            ro_sel_q      <= '0;
            mask_q        <= '0;
            data_q        <= '0;
            meas_valid_q  <= 1'b0;
            meas_id_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ro_sel_q      <= ro_sel_d;
            mask_q        <= mask_d;
            data_q        <= data_d;
            meas_valid_q  <= meas_valid_d;
            meas_id_q     <= meas_id_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Registered outputs exposed directly.
    always_comb begin
        ro_sel      = ro_sel_q;
        send_data   = data_q;
        busy        = (state_q != StIdle);
        meas_valid  = meas_valid_q;
        meas_id     = meas_id_q;
        timeout_err = timeout_err_q;
    end

endmodule

// File: doc/ro_scan_scheduler.md
Name: ro_scan_scheduler

Overview:
- Sequences ring-oscillator frequency measurements across N_RO oscillators sharing one edge counter and one UART sender.
- Per channel: selects and enables the RO, settles, opens a fixed gate window on the shared counter, latches the count, hands it to the UART sender and waits for its done.
- Sits between the top-level measurement control (start, mask) and the counter and UART send blocks.

Parameters:
- N_RO, 4, number of ring oscillators (1..16)
- GATE_CYCLES, 1000000, gate window length in clk cycles (>=1)
- SETTLE_CYCLES, 16, cycles between RO enable and gate open (>=1)
- SEND_TIMEOUT, 2000000, max clk cycles waiting for send_done

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin a scan (ignored unless IDLE)
- continuous  in  1  1 = restart scan automatically after the last channel
- ro_mask  in  N_RO  channel enable mask; sampled at scan start
- ro_sel  out  IDX_W = max(1, clog2(N_RO))  selected RO index
- ro_en  out  1  enable for the selected RO
- cnt_clear  out  1  one-cycle clear pulse to the edge counter
- cnt_gate  out  1  counter gate; high for exactly GATE_CYCLES cycles
- cnt_value  in  32  counter result; valid 2 cycles after cnt_gate falls
- send_data  out  32  word for the UART sender
- send_req  out  1  one-cycle transmit pulse
- send_done  in  1  one-cycle pulse from the sender at end of frame
- busy  out  1  high in any state other than IDLE
- meas_valid  out  1  one-cycle pulse when a count is latched
- meas_id  out  IDX_W  channel of the latched count
- timeout_err  out  1  sticky; set on send timeout, cleared by rst or start

Behaviour:
- Reset values: all outputs 0, state IDLE, latched mask 0.
- States: IDLE, SETTLE, GATE, DRAIN, SEND, WAIT_DONE, NEXT.
- IDLE:
  - On start with ro_mask != 0: latch the mask, clear timeout_err, set ro_sel to the lowest set bit, go to SETTLE.
  - On start with ro_mask == 0: stay IDLE; busy stays 0.
- SETTLE:
  - ro_en = 1.
  - cnt_clear pulses in the first cycle.
  - After SETTLE_CYCLES cycles, go to GATE.
- GATE:
  - ro_en = 1, cnt_gate = 1 for exactly GATE_CYCLES cycles, counted by an internal 32-bit counter.
  - Then go to DRAIN.
- DRAIN:
  - 2 cycles with ro_en = 1 and cnt_gate = 0 (counter synchroniser latency).
  - On the 2nd cycle: latch cnt_value, pulse meas_valid, drive meas_id = ro_sel, go to SEND.
- SEND:
  - ro_en = 0.
  - send_data = latched word, held stable until the next latch.
  - send_req pulses for 1 cycle, then go to WAIT_DONE.
- WAIT_DONE:
  - On send_done, go to NEXT.
  - After SEND_TIMEOUT cycles without send_done: set timeout_err, go to NEXT (scan continues).
  - A send_done arriving in any other state is ignored.
- NEXT:
  - Search the latched mask for the next set bit above ro_sel.
  - Found: update ro_sel, go to SETTLE.
  - None found and continuous = 1: wrap to the lowest set bit, go to SETTLE. The mask is NOT resampled.
  - None found and continuous = 0: go to IDLE.
- Only one RO is enabled at a time; ro_en is never high in IDLE, SEND, WAIT_DONE or NEXT.
- Scan latency per channel (send_done immediate): SETTLE_CYCLES + GATE_CYCLES + 2 + 1 + 1 + 1 cycles.
- start while busy: ignored (no restart, no timeout_err clear).
- rst mid-operation: immediate return to IDLE, all outputs 0 on the following cycle, pending send abandoned.
- A single-bit mask repeats the same channel; in continuous mode this loops indefinitely.

Optional Feature:
- Macro: RO_SCAN_TAG_EN.
- Defined: send_data = {4'(ro_sel), cnt[27:0]}.
  - The count saturates to 28'hFFFFFFF if cnt_value[31:28] != 0.
  - The host can identify the channel from the word.
- Undefined: send_data = cnt_value raw (32 bits), no tagging, no saturation.

Test Plan:
- N_RO=4, GATE_CYCLES=100, SETTLE_CYCLES=4, mask 4'b1011, continuous=0, start, send_done 5 cycles after each send_req, cnt_value returns 100+ro_sel -> meas_id sequence 0,1,3; send_data 100,101,103; then IDLE with busy=0.
- Same config with continuous=1 for 2 scans -> meas_id sequence 0,1,3,0,1,3; mask changed to 4'b0001 mid-scan has no effect.
- Gate and settle timing: cnt_gate high exactly 100 cycles; cnt_clear pulses 4 cycles before gate rise; ro_en falls 2 cycles after gate fall.
- SEND_TIMEOUT=50, send_done never asserted, mask 4'b0011 -> timeout_err=1 after the first word; second channel still measured; next start clears the flag.
- rst asserted during GATE of channel 1 -> next cycle all outputs 0, state IDLE; start with mask 0 -> busy stays 0.
- RO_SCAN_TAG_EN defined, ro_sel=2, cnt_value=32'h1000_0005 -> send_data=32'h2FFF_FFFF; cnt_value=32'h0000_0123 -> send_data=32'h2000_0123.
